fir_decimate: RTL and testbench

- Audio-path stage directly downstream of the FM demodulator.
- Consumes 32-bit Q10 demodulated samples from the demod output FIFO and applies a NUM_TAPS-tap real FIR low-pass filter.
- Decimates by DECIM and writes one filtered sample per DECIM inputs into the audio FIFO.
- Uses a single time-shared multiply-accumulate (MAC): one tap per cycle.

---
 rtl/fir_decimate_pkg.sv | 37 +++
 rtl/fir_decimate_if.sv | 26 ++
 rtl/fir_decimate_coeff_rom.sv | 19 +
 rtl/fir_decimate.sv | 139 +++++++++++++
 tb/tb_fir_decimate.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_decimate_pkg.sv
// Shared audio-path definitions: sample width, Q-format, FSM states, LPR coefficients.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fir_pkg;

    localparam int SAMPLE_W       = 32;
    localparam int QUANT_BITS     = 10;
    localparam int AUDIO_LPR_TAPS = 32;

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_OUT
    } fir_state_t;

    // Audio L+R low-pass taps, signed Q10; element 0 pairs with the newest sample.
    localparam logic [0:AUDIO_LPR_TAPS-1][SAMPLE_W-1:0] AUDIO_LPR_COEFFS = {
        -32'sd3,   -32'sd6,   -32'sd12,  -32'sd19,  -32'sd27,  -32'sd33,  -32'sd30,  -32'sd13,
         32'sd21,   32'sd78,   32'sd155,  32'sd249,  32'sd349,  32'sd446,  32'sd526,  32'sd579,
         32'sd579,  32'sd526,  32'sd446,  32'sd349,  32'sd249,  32'sd155,  32'sd78,   32'sd21,
        -32'sd13,  -32'sd30,  -32'sd33,  -32'sd27,  -32'sd19,  -32'sd12,  -32'sd6,   -32'sd3
    };

    // Drop 'bits' fraction bits, rounding toward zero: negatives get a bias of
    // 2^bits-1 before the arithmetic shift so that e.g. -1 maps to 0, not -1.
    function automatic logic signed [SAMPLE_W-1:0] dequantize(
        input logic signed [SAMPLE_W-1:0] x,
        input int                         bits
    );
        logic signed [SAMPLE_W-1:0] bias;
        logic signed [SAMPLE_W-1:0] biased;
        bias   = (32'sd1 <<< bits) - 32'sd1;
        biased = (x < 0) ? x + bias : x;
        return biased >>> bits;
    endfunction

endpackage

// File: rtl/fir_decimate_if.sv
// FIFO-side bundle of the decimating FIR: upstream pop port plus downstream push port.
// Latency: n/a (wires only); rd_en/wr_en act in the same cycle as the data.
// Backpressure: in_empty stalls reads, out_full stalls writes.
interface fir_decimate_if;
    import fir_pkg::*;

    logic                       in_empty;
    logic                       in_rd_en;
    logic signed [SAMPLE_W-1:0] in_dout;
    logic                       out_full;
    logic                       out_wr_en;
    logic signed [SAMPLE_W-1:0] out_din;

    // Filter side: pops the demod FIFO, pushes the audio FIFO.
    modport master (
        input  in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, out_din
    );

    // FIFO side.
    modport slave (
        output in_empty, in_dout, out_full,
        input  in_rd_en, out_wr_en, out_din
    );

endinterface

// File: rtl/fir_decimate_coeff_rom.sv
// Combinational tap index -> coefficient lookup, coefficient set chosen by parameter.
// Latency: 0 cycles.
// Backpressure: none (pure lookup).
module fir_coeff_rom
    import fir_pkg::*;
#(
    parameter int                                    NUM_TAPS = 32,
    parameter logic [0:NUM_TAPS-1][SAMPLE_W-1:0]     COEFFS   = AUDIO_LPR_COEFFS
) (
    input  logic [$clog2(NUM_TAPS)-1:0] tap_idx,
    output logic signed [SAMPLE_W-1:0]  coeff
);

    // Index the packed coefficient table.
    always_comb begin
        coeff = $signed(COEFFS[tap_idx]);
    end

endmodule

// File: rtl/fir_decimate.sv
// Decimating real FIR: loads DECIM samples, runs NUM_TAPS MAC cycles, emits one sample.
// Latency: NUM_TAPS+1 cycles from the DECIM-th pop to out_wr_en; period DECIM+NUM_TAPS+1.
// Backpressure: holds in S_OUT with out_din stable while out_full; never reads while busy.
module fir_decimate
    import fir_pkg::*;
#(
    parameter int                                NUM_TAPS = 32,
    parameter int                                DECIM    = 8,
    parameter int                                BITS     = QUANT_BITS,
    parameter logic [0:NUM_TAPS-1][SAMPLE_W-1:0] COEFFS   = AUDIO_LPR_COEFFS
) (
    input  logic           clk,
    input  logic           reset,
    fir_decimate_if.master bus
);

    localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(DECIM - 1);

    fir_state_t                 state;
    fir_state_t                 state_nxt;
    logic [CNT_W-1:0]           load_cnt;
    logic [TAP_W-1:0]           tap_idx;
    logic signed [SAMPLE_W-1:0] acc;
    logic signed [SAMPLE_W-1:0] sample_buf [NUM_TAPS];
    logic signed [SAMPLE_W-1:0] coeff;
    logic signed [SAMPLE_W-1:0] term;
    logic signed [SAMPLE_W-1:0] acc_sum;
    logic                       pop;
    logic                       push;

    fir_coeff_rom #(
        .NUM_TAPS (NUM_TAPS),
        .COEFFS   (COEFFS)
    ) u_coeff_rom (
        .tap_idx (tap_idx),
        .coeff   (coeff)
    );

    // Next state and FIFO strobes; strobes are derived from state only.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        push      = 1'b0;
        case (state)
            S_LOAD: begin
                if (!bus.in_empty) begin
                    pop = 1'b1;
                    if (load_cnt == LAST_LOAD) begin
                        state_nxt = S_MAC;
                    end
                end
            end
            S_MAC: begin
                if (tap_idx == LAST_TAP) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (!bus.out_full) begin
                    push      = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // Strobes are forced low while reset is held so no FIFO moves during reset.
    assign bus.in_rd_en  = pop & reset;
    assign bus.out_wr_en = push & reset;

    // One MAC term: the low word of the 64-bit product equals the wrapped
    // 32-bit product, so only that word is formed before dequantizing.
    always_comb begin
        term    = dequantize(coeff * sample_buf[tap_idx], BITS);
        acc_sum = acc + term;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Sample history: shift in on every pop, index 0 is the newest sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                sample_buf[k] <= '0;
            end
        end else if (pop) begin
            sample_buf[0] <= bus.in_dout;
            for (int k = 1; k < NUM_TAPS; k++) begin
                sample_buf[k] <= sample_buf[k-1];
            end
        end
    end

    // Load counter, tap walk, accumulator and the registered output sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt    <= '0;
            tap_idx     <= '0;
            acc         <= '0;
            bus.out_din <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (pop) begin
                        if (load_cnt == LAST_LOAD) begin
                            load_cnt <= '0;
                            tap_idx  <= '0;
                            acc      <= '0;
                        end else begin
                            load_cnt <= load_cnt + CNT_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_sum;
                    if (tap_idx == LAST_TAP) begin
                        bus.out_din <= acc_sum;
                    end else begin
                        tap_idx <= tap_idx + TAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimate.sv
// Directed bench for fir_decimate: LPR instance plus a unit-tap (c[0]=1) instance on shared stimulus.
// Latency: n/a.
// Backpressure: bench models the upstream FIFO (with optional gaps) and the downstream full flag.
module tb_fir_decimate;
    import fir_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                in_empty;
    logic                out_full;
    logic signed [31:0]  in_dout;

    fir_decimate_if ifa ();
    fir_decimate_if ifb ();

    assign ifa.in_empty = in_empty;
    assign ifa.in_dout  = in_dout;
    assign ifa.out_full = out_full;
    assign ifb.in_empty = in_empty;
    assign ifb.in_dout  = in_dout;
    assign ifb.out_full = out_full;

    localparam logic [0:31][31:0] UNIT_COEFFS = {32'd1, {31{32'd0}}};

    fir_decimate #(.NUM_TAPS(32), .DECIM(8), .BITS(10)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    fir_decimate #(.NUM_TAPS(32), .DECIM(8), .BITS(10), .COEFFS(UNIT_COEFFS)) u_unit (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int viol  = 0;
    bit gap_en = 1'b0;

    logic signed [31:0] src_q [$];
    logic signed [31:0] got_a [$];
    logic signed [31:0] got_b [$];

    logic               last_rd;
    logic               last_wr;
    logic signed [31:0] last_dout;

    typedef struct {
        string              name;
        bit                 rst;
        bit                 gap;
        logic signed [31:0] first;
        logic signed [31:0] mid;
        logic signed [31:0] last;
        logic signed [31:0] exp_a;
        logic signed [31:0] exp_b;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mkv(string n, bit r, bit g, int f, int m, int l, int ea, int eb);
        vec_t v;
        v.name = n; v.rst = r; v.gap = g;
        v.first = f; v.mid = m; v.last = l;
        v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive FIFO model, sample DUT at negedge, apply pops/pushes after posedge.
    task automatic tick();
        logic wrb;
        logic signed [31:0] db;
        in_empty = (src_q.size() == 0) || (gap_en && (cyc % 2 == 1));
        in_dout  = (src_q.size() != 0) ? src_q[0] : 32'sd0;
        @(negedge clk);
        last_rd   = ifa.in_rd_en;
        last_wr   = ifa.out_wr_en;
        last_dout = ifa.out_din;
        wrb       = ifb.out_wr_en;
        db        = ifb.out_din;
        if (last_rd && in_empty) viol++;
        @(posedge clk);
        #1;
        cyc++;
        if (last_rd && src_q.size() != 0) void'(src_q.pop_front());
        if (last_wr) got_a.push_back(last_dout);
        if (wrb) got_b.push_back(db);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int pops;
        int bad;
        int t_pop;
        int t_wr1;
        int t_wr2;
        logic signed [31:0] hold_val;

        reset    = 1'b0;
        out_full = 1'b0;
        in_empty = 1'b1;
        in_dout  = '0;

        // Reset state: strobes low even with data offered, outputs cleared.
        src_q.push_back(32'sd1024);
        repeat (2) tick();
        check("reset_rd_en", last_rd, 1'b0);
        check("reset_wr_en", last_wr, 1'b0);
        check("reset_out_din", last_dout, 32'sd0);
        check("reset_unit_out_din", ifb.out_din, 32'sd0);
        src_q.delete();
        reset = 1'b1;

        // DC 1.0: partial sums while history fills, then full-window sum.
        vecs.push_back(mkv("dc0", 1, 0, 1024, 1024, 1024, -143, 1));
        vecs.push_back(mkv("dc1", 0, 0, 1024, 1024, 1024, 2260, 1));
        vecs.push_back(mkv("dc2", 0, 0, 1024, 1024, 1024, 4663, 1));
        for (int i = 3; i < 8; i++)
            vecs.push_back(mkv($sformatf("dc%0d", i), 0, 0, 1024, 1024, 1024, 4520, 1));
        // Impulse walks through taps 7, 15, 23, 31, then leaves the window.
        vecs.push_back(mkv("imp0", 1, 0, 1024, 0, 0, -13, 0));
        vecs.push_back(mkv("imp1", 0, 0, 0, 0, 0, 579, 0));
        vecs.push_back(mkv("imp2", 0, 0, 0, 0, 0, 21, 0));
        vecs.push_back(mkv("imp3", 0, 0, 0, 0, 0, -3, 0));
        vecs.push_back(mkv("imp4", 0, 0, 0, 0, 0, 0, 0));
        // Toward-zero rounding; unit instance output is dequantize(newest sample).
        vecs.push_back(mkv("rnd_m1_first", 1, 0, -1, 0, 0, 0, 0));
        vecs.push_back(mkv("rnd_m1_last", 0, 0, 0, 0, -1, 0, 0));
        vecs.push_back(mkv("rnd_m2047", 0, 0, 0, 0, -2047, 5, -1));
        vecs.push_back(mkv("rnd_p2047", 0, 0, 0, 0, 2047, -46, 1));
        // DC again with an empty flag toggling every other cycle.
        vecs.push_back(mkv("gap0", 1, 1, 1024, 1024, 1024, -143, 1));
        vecs.push_back(mkv("gap1", 0, 1, 1024, 1024, 1024, 2260, 1));
        vecs.push_back(mkv("gap2", 0, 1, 1024, 1024, 1024, 4663, 1));
        for (int i = 3; i < 8; i++)
            vecs.push_back(mkv($sformatf("gap%0d", i), 0, 1, 1024, 1024, 1024, 4520, 1));

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].rst) do_reset();
            gap_en = vecs[v].gap;
            src_q.push_back(vecs[v].first);
            repeat (6) src_q.push_back(vecs[v].mid);
            src_q.push_back(vecs[v].last);
            base = got_a.size();
            for (int t = 0; t < 200 && got_a.size() == base; t++) tick();
            repeat (2) tick();
            check({vecs[v].name, "_count"}, got_a.size(), base + 1);
            if (got_a.size() > base) check({vecs[v].name, "_out"}, got_a[base], vecs[v].exp_a);
            if (got_b.size() > base) check({vecs[v].name, "_unit"}, got_b[base], vecs[v].exp_b);
        end
        gap_en = 1'b0;

        // Backpressure: 20+ cycles held in S_OUT with more input waiting.
        do_reset();
        out_full = 1'b1;
        repeat (16) src_q.push_back(32'sd1024);
        base = got_a.size();
        for (int t = 0; t < 100 && last_dout == 0; t++) tick();
        hold_val = last_dout;
        bad = 0;
        repeat (20) begin
            tick();
            if (last_wr || last_rd || last_dout !== hold_val) bad++;
        end
        check("bp_hold_value", hold_val, -32'sd143);
        check("bp_hold_violations", bad, 0);
        check("bp_no_reads", src_q.size(), 8);
        out_full = 1'b0;
        tick();
        check("bp_release_pulse", last_wr, 1'b1);
        check("bp_release_count", got_a.size(), base + 1);
        tick();
        check("bp_single_pulse", last_wr, 1'b0);
        check("bp_resume_read", last_rd, 1'b1);

        // Reset at tap 10 of a block of 512s; next block must see clean history.
        src_q.delete();
        do_reset();
        repeat (8) src_q.push_back(32'sd512);
        pops = 0;
        for (int t = 0; t < 50 && pops < 8; t++) begin
            tick();
            if (last_rd) pops++;
        end
        repeat (10) tick();
        src_q.delete();
        repeat (8) src_q.push_back(32'sd1024);
        reset = 1'b0;
        base = got_a.size();
        bad = 0;
        repeat (3) begin
            tick();
            if (last_rd || last_wr || last_dout !== 0) bad++;
        end
        check("midmac_reset_strobes", bad, 0);
        check("midmac_no_pop", src_q.size(), 8);
        reset = 1'b1;
        for (int t = 0; t < 200 && got_a.size() == base; t++) tick();
        repeat (2) tick();
        check("midmac_count", got_a.size(), base + 1);
        if (got_a.size() > base) check("midmac_out", got_a[base], -32'sd143);

        // Latency from the 8th pop to the write, and output period.
        do_reset();
        repeat (16) src_q.push_back(32'sd1024);
        pops = 0; t_pop = -1; t_wr1 = -1; t_wr2 = -1;
        for (int t = 0; t < 200 && t_wr2 < 0; t++) begin
            tick();
            if (last_rd) begin
                pops++;
                if (pops == 8) t_pop = cyc;
            end
            if (last_wr) begin
                if (t_wr1 < 0) t_wr1 = cyc;
                else t_wr2 = cyc;
            end
        end
        check("latency", t_wr1 - t_pop, 33);
        check("period", t_wr2 - t_wr1, 41);

        // A partial block is consumed but produces no output.
        base = got_a.size();
        repeat (5) src_q.push_back(32'sd1024);
        repeat (100) tick();
        check("partial_consumed", src_q.size(), 0);
        check("partial_no_output", got_a.size(), base);

        check("no_pop_when_empty", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
